// File: rtl/event_scheduler.sv
// ---------------------------------------------------------------------------
// event_scheduler
// Captures rising edges on N_CH event channels and timestamps each one with
// (count + delay). Pending stamps are handed to a downstream FIFO one per
// cycle, with round-robin arbitration between channels. A free-running
// timebase (count) is exported for the downstream comparator.
//
// Parameters
//   WIDTH        width of count, delay and timestamps
//   N_CH         number of event input channels
// Ports
//   clk          system clock, rising edge
//   n_rst        synchronous active-low reset
//   enable       run control: counting and scheduling when high
//   delay        cycles added to each captured timestamp
//   event_in     per-channel event levels, rising edge = event
//   full         FIFO full flag, blocks writes
//   clr_overflow clears the sticky overflow flag
//   wr_en        FIFO write strobe (combinational)
//   wr_data      due timestamp of the granted channel (combinational)
//   count        free-running timebase
//   pending      per-channel captured-but-unwritten flags
//   overflow     sticky flag, an event was lost
// ---------------------------------------------------------------------------
module event_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] delay,
    input  logic [N_CH-1:0]  event_in,
    input  logic             full,
    input  logic             clr_overflow,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count,
    output logic [N_CH-1:0]  pending,
    output logic             overflow
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [WIDTH-1:0] count_q,   count_d;
    logic [N_CH-1:0]  prev_in_q, prev_in_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [WIDTH-1:0] stamp_q [N_CH];
    logic [WIDTH-1:0] stamp_d [N_CH];
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] rr_ptr_q,  rr_ptr_d;

    logic [N_CH-1:0]  evt_edge;
    logic [PTR_W-1:0] grant;

    assign evt_edge = event_in & ~prev_in_q;

    // Round-robin grant: nearest pending channel above rr_ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx   = rr_ptr_q;
        grant = rr_ptr_q;
        for (int k = int'(N_CH); k >= 1; k--) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % int'(N_CH));
            if (pending_q[idx]) begin
                grant = idx;
            end
        end
    end

    // FIFO write port; n_rst gates the strobe during reset cycles.
    assign wr_en   = enable & ~full & (|pending_q) & n_rst;
    assign wr_data = stamp_q[grant];

    // Next-state logic for timebase, edge capture and scheduling state.
    always_comb begin
        count_d    = enable ? count_q + WIDTH'(1) : count_q;
        prev_in_d  = event_in;
        pending_d  = pending_q;
        stamp_d    = stamp_q;
        overflow_d = overflow_q & ~clr_overflow;
        rr_ptr_d   = rr_ptr_q;

        if (wr_en) begin
            pending_d[grant] = 1'b0;
            rr_ptr_d         = grant;
        end

        // A channel freed by this cycle's write may accept a new edge;
        // otherwise an edge on a still-pending channel is lost.
        if (enable) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (evt_edge[i]) begin
                    if (pending_d[i]) begin
                        overflow_d = 1'b1;
                    end else begin
                        pending_d[i] = 1'b1;
                        stamp_d[i]   = count_q + delay;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset; rr_ptr starts at the last
    // channel so channel 0 is served first.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q    <= '0;
            prev_in_q  <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            rr_ptr_q   <= PTR_W'(N_CH - 1);
            for (int i = 0; i < int'(N_CH); i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            prev_in_q  <= prev_in_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                stamp_q[i] <= stamp_d[i];
            end
        end
    end

    assign count    = count_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_event_scheduler
// Directed bench for event_scheduler (WIDTH=8, N_CH=4). Inputs change 1 time
// unit after the rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_event_scheduler;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       enable;
    logic [7:0] delay;
    logic [3:0] event_in;
    logic       full;
    logic       clr_overflow;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] count;
    logic [3:0] pending;
    logic       overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    event_scheduler #(.WIDTH(8), .N_CH(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .delay        (delay),
        .event_in     (event_in),
        .full         (full),
        .clr_overflow (clr_overflow),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .count        (count),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; enable = 1'b0; event_in = 4'b0000; full = 1'b0;
        clr_overflow = 1'b0; delay = 8'd0;
        tick();
        tick();
        n_rst  = 1'b1;
        enable = 1'b1;
    endtask

    task automatic wait_count(input logic [7:0] target);
        int budget;
        budget = 0;
        while (count !== target && budget < 600) begin
            tick();
            budget++;
        end
        n_compared++;
        if (count !== target) begin
            $display("FAIL wait_count: count=%0d required %0d", count, target);
            n_mismatched++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; enable = 1'b1; event_in = 4'b1111; full = 1'b0;
        clr_overflow = 1'b1; delay = 8'd7;
        tick();
        tick();
        n_compared++;
        if (count !== 8'd0) begin
            $display("FAIL reset_count: got %0d required 0", count); n_mismatched++;
        end
        n_compared++;
        if (pending !== 4'b0000) begin
            $display("FAIL reset_pending: got %b required 0000", pending); n_mismatched++;
        end
        n_compared++;
        if (overflow !== 1'b0) begin
            $display("FAIL reset_overflow: got %b required 0", overflow); n_mismatched++;
        end
        n_compared++;
        if (wr_en !== 1'b0) begin
            $display("FAIL reset_wr_en: got %b required 0", wr_en); n_mismatched++;
        end
        event_in = 4'b0000;
        clr_overflow = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        delay = 8'd10;
        wait_count(8'd5);
        event_in = 4'b0001;
        tick();
        n_compared++;
        if (wr_en !== 1'b1 || wr_data !== 8'd15) begin
            $display("FAIL single_write: wr_en=%b wr_data=%0d required 1/15", wr_en, wr_data);
            n_mismatched++;
        end
        n_compared++;
        if (pending !== 4'b0001 || count !== 8'd6) begin
            $display("FAIL single_capture: pending=%b count=%0d required 0001/6", pending, count);
            n_mismatched++;
        end
        tick();
        n_compared++;
        if (pending !== 4'b0000 || wr_en !== 1'b0) begin
            $display("FAIL single_drain: pending=%b wr_en=%b required 0000/0", pending, wr_en);
            n_mismatched++;
        end
        event_in = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_pend [4];
        logic [3:0] exp_pend2 [2];
        exp_pend  = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        exp_pend2 = '{4'b0100, 4'b0000};
        do_reset();
        delay = 8'd3;
        wait_count(8'd20);
        event_in = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (wr_en !== 1'b1 || wr_data !== 8'd23) begin
                $display("FAIL burst_write%0d: wr_en=%b wr_data=%0d required 1/23", i, wr_en, wr_data);
                n_mismatched++;
            end
            tick();
            n_compared++;
            if (pending !== exp_pend[i]) begin
                $display("FAIL burst_grant%0d: pending=%b required %b", i, pending, exp_pend[i]);
                n_mismatched++;
            end
        end
        event_in = 4'b0000;
        tick();
        event_in = 4'b0101;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_compared++;
            if (wr_en !== 1'b1 || wr_data !== 8'd29) begin
                $display("FAIL rr_write%0d: wr_en=%b wr_data=%0d required 1/29", i, wr_en, wr_data);
                n_mismatched++;
            end
            tick();
            n_compared++;
            if (pending !== exp_pend2[i]) begin
                $display("FAIL rr_grant%0d: pending=%b required %b", i, pending, exp_pend2[i]);
                n_mismatched++;
            end
        end
        event_in = 4'b0000;
    endtask

    task automatic test_wrap();
        do_reset();
        delay = 8'd10;
        wait_count(8'd250);
        event_in = 4'b0010;
        tick();
        n_compared++;
        if (wr_en !== 1'b1 || wr_data !== 8'd4 || pending !== 4'b0010) begin
            $display("FAIL wrap_stamp: wr_en=%b wr_data=%0d pending=%b required 1/4/0010",
                     wr_en, wr_data, pending);
            n_mismatched++;
        end
        tick();
        n_compared++;
        if (pending !== 4'b0000) begin
            $display("FAIL wrap_drain: pending=%b required 0000", pending); n_mismatched++;
        end
        event_in = 4'b0000;
    endtask

    task automatic test_full();
        do_reset();
        delay = 8'd10;
        wait_count(8'd30);
        full = 1'b1;
        event_in = 4'b0010;
        tick();
        n_compared++;
        if (wr_en !== 1'b0 || pending !== 4'b0010) begin
            $display("FAIL full_hold1: wr_en=%b pending=%b required 0/0010", wr_en, pending);
            n_mismatched++;
        end
        event_in = 4'b0000;
        tick();
        event_in = 4'b0010;
        tick();
        n_compared++;
        if (overflow !== 1'b1 || pending !== 4'b0010 || wr_en !== 1'b0) begin
            $display("FAIL full_overflow: overflow=%b pending=%b wr_en=%b required 1/0010/0",
                     overflow, pending, wr_en);
            n_mismatched++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_compared++;
            if (wr_en !== 1'b0) begin
                $display("FAIL full_block%0d: wr_en=%b required 0", i, wr_en); n_mismatched++;
            end
        end
        full = 1'b0;
        settle();
        n_compared++;
        if (wr_en !== 1'b1 || wr_data !== 8'd40) begin
            $display("FAIL full_release: wr_en=%b wr_data=%0d required 1/40", wr_en, wr_data);
            n_mismatched++;
        end
        tick();
        n_compared++;
        if (wr_en !== 1'b0 || pending !== 4'b0000 || overflow !== 1'b1) begin
            $display("FAIL full_single: wr_en=%b pending=%b overflow=%b required 0/0000/1",
                     wr_en, pending, overflow);
            n_mismatched++;
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_compared++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_clear: overflow=%b required 0", overflow); n_mismatched++;
        end
        // Set and clear in the same cycle: set wins.
        full = 1'b1;
        event_in = 4'b0000;
        tick();
        event_in = 4'b0010;
        tick();
        event_in = 4'b0000;
        tick();
        event_in = 4'b0010;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_compared++;
        if (overflow !== 1'b1) begin
            $display("FAIL ovf_set_wins: overflow=%b required 1", overflow); n_mismatched++;
        end
        full = 1'b0;
        event_in = 4'b0000;
    endtask

    task automatic test_rewrite();
        do_reset();
        delay = 8'd5;
        full = 1'b1;
        wait_count(8'd10);
        event_in = 4'b1000;
        tick();
        event_in = 4'b0000;
        tick();
        full = 1'b0;
        event_in = 4'b1000;
        settle();
        n_compared++;
        if (wr_en !== 1'b1 || wr_data !== 8'd15) begin
            $display("FAIL rewrite_first: wr_en=%b wr_data=%0d required 1/15", wr_en, wr_data);
            n_mismatched++;
        end
        tick();
        n_compared++;
        if (pending !== 4'b1000 || wr_data !== 8'd17 || overflow !== 1'b0) begin
            $display("FAIL rewrite_reload: pending=%b wr_data=%0d overflow=%b required 1000/17/0",
                     pending, wr_data, overflow);
            n_mismatched++;
        end
        tick();
        n_compared++;
        if (pending !== 4'b0000) begin
            $display("FAIL rewrite_drain: pending=%b required 0000", pending); n_mismatched++;
        end
        event_in = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        delay = 8'd3;
        wait_count(8'd8);
        event_in = 4'b1111;
        tick();
        tick();
        n_compared++;
        if (pending !== 4'b1110) begin
            $display("FAIL midrst_before: pending=%b required 1110", pending); n_mismatched++;
        end
        n_rst = 1'b0;
        event_in = 4'b0000;
        settle();
        n_compared++;
        if (wr_en !== 1'b0) begin
            $display("FAIL midrst_wr_en: wr_en=%b required 0", wr_en); n_mismatched++;
        end
        tick();
        n_compared++;
        if (count !== 8'd0 || pending !== 4'b0000 || wr_en !== 1'b0) begin
            $display("FAIL midrst_state: count=%0d pending=%b wr_en=%b required 0/0000/0",
                     count, pending, wr_en);
            n_mismatched++;
        end
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++;
            if (wr_en !== 1'b0 || pending !== 4'b0000) begin
                $display("FAIL midrst_quiet%0d: wr_en=%b pending=%b required 0/0000", i, wr_en, pending);
                n_mismatched++;
            end
        end
    endtask

    task automatic test_disable();
        do_reset();
        wait_count(8'd77);
        enable = 1'b0;
        event_in = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++;
            if (count !== 8'd77 || pending !== 4'b0000 || wr_en !== 1'b0) begin
                $display("FAIL disable%0d: count=%0d pending=%b wr_en=%b required 77/0000/0",
                         i, count, pending, wr_en);
                n_mismatched++;
            end
        end
        enable = 1'b1;
        tick();
        n_compared++;
        if (count !== 8'd78 || pending !== 4'b0000) begin
            $display("FAIL disable_resume: count=%0d pending=%b required 78/0000", count, pending);
            n_mismatched++;
        end
        event_in = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_full();
        test_rewrite();
        test_reset_mid();
        test_disable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
